// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and legal frame-format ranges.
// Used by uart_tx, uart_rx and the baud-tick generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_e;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Bit counter must span the longer of the data and stop phases.
  localparam int BIT_CNT_W = $clog2(DATA_BITS_MAX);

  localparam int BAUD_W = 16;

endpackage

// File: rtl/uart_baud.sv
// Baud-rate tick generator: Tick is a 1-cycle pulse every BaudRate+1 clocks
// (continuously high when BaudRate=0).
module uart_baud
  import uart_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [BAUD_W-1:0] BaudRate,
  output logic              Tick
);

  localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);

  logic [BAUD_W-1:0] r_cnt;
  logic              w_tick;

  // >= rather than == so a lowered BaudRate never strands the counter above it.
  assign w_tick = (r_cnt >= BaudRate);
  assign Tick   = w_tick;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART serialiser: one byte per valid/ready handshake, sent LSB-first as
// start, data, optional parity and 1-2 stop bits, one bit per Tick interval.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
)
(
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Tick,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Tx_Valid,
  output logic                 Tx_Ready,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Tx_Done
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] CNT_ONE   = BIT_CNT_W'(1);
  localparam logic                 ODD_BIT   = (PARITY_ODD != 0);
  localparam uart_state_e          AFTER_DATA = (PARITY_EN != 0) ? PARITY : STOP;

  uart_state_e            r_state, w_state_next;
  logic [DATA_BITS-1:0]   r_shift, w_shift_next;
  logic [BIT_CNT_W-1:0]   r_cnt,   w_cnt_next;
  logic                   r_parity, w_parity_next;
  logic                   r_tx,     w_tx_next;
  logic                   w_done;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_cnt    <= w_cnt_next;
      r_parity <= w_parity_next;
      r_tx     <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_cnt_next    = r_cnt;
    w_parity_next = r_parity;
    w_done        = 1'b0;

    unique case (r_state)
      // A Tick coinciding with the handshake is deliberately ignored here.
      IDLE: begin
        if (Tx_Valid) begin
          w_shift_next  = Tx_Data;
          w_parity_next = (^Tx_Data) ^ ODD_BIT;
          w_cnt_next    = '0;
          w_state_next  = SYNC;
        end
      end
      SYNC: begin
        if (Tick) w_state_next = START;
      end
      START: begin
        if (Tick) begin
          w_cnt_next   = '0;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (Tick) begin
          w_shift_next = r_shift >> 1;
          if (r_cnt == LAST_DATA) begin
            w_cnt_next   = '0;
            w_state_next = AFTER_DATA;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
      end
      PARITY: begin
        if (Tick) begin
          w_cnt_next   = '0;
          w_state_next = STOP;
        end
      end
      STOP: begin
        if (Tick) begin
          if (r_cnt == LAST_STOP) begin
            w_cnt_next   = '0;
            w_done       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Line level is derived from the next state so every bit registers on the
  // same edge as its state change, keeping all bit widths identical.
  always_comb begin
    w_tx_next = 1'b1;
    unique case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = w_parity_next;
      default: w_tx_next = 1'b1;
    endcase
  end

  assign Tx       = r_tx;
  assign Tx_Ready = (r_state == IDLE);
  assign Busy     = ~Tx_Ready;
  assign Tx_Done  = w_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx driven by uart_baud: three frame formats
// (8N1, 8E2, 8O1) share one tick generator.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud;
  logic        tick;
  logic [2:0]  valid;
  logic [7:0]  data [3];

  logic tx0, tx1, tx2, rdy0, rdy1, rdy2, bsy0, bsy1, bsy2, dn0, dn1, dn2;
  logic [2:0] tx_v, rdy_v, bsy_v, dn_v;
  assign tx_v  = {tx2, tx1, tx0};
  assign rdy_v = {rdy2, rdy1, rdy0};
  assign bsy_v = {bsy2, bsy1, bsy0};
  assign dn_v  = {dn2, dn1, dn0};

  int checks   = 0;
  int failures = 0;

  logic [7:0] hs_data [$];
  int         dn0_total = 0;

  always #5 clk = ~clk;

  uart_baud u_baud (
    .Clk(clk), .Rst_n(rst_n), .BaudRate(baud), .Tick(tick)
  );

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .Clk(clk), .Rst_n(rst_n), .Tick(tick), .Tx_Data(data[0]), .Tx_Valid(valid[0]),
    .Tx_Ready(rdy0), .Tx(tx0), .Busy(bsy0), .Tx_Done(dn0)
  );

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
    .Clk(clk), .Rst_n(rst_n), .Tick(tick), .Tx_Data(data[1]), .Tx_Valid(valid[1]),
    .Tx_Ready(rdy1), .Tx(tx1), .Busy(bsy1), .Tx_Done(dn1)
  );

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .Clk(clk), .Rst_n(rst_n), .Tick(tick), .Tx_Data(data[2]), .Tx_Valid(valid[2]),
    .Tx_Ready(rdy2), .Tx(tx2), .Busy(bsy2), .Tx_Done(dn2)
  );

  // Log of bytes accepted by the 8N1 instance, and its Tx_Done pulse count.
  always @(posedge clk) begin
    if (rst_n && valid[0] && rdy0) hs_data.push_back(data[0]);
    if (dn0) dn0_total++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expand a frame bit list (index 0 = start bit) into a per-clock line trace.
  function automatic logic [63:0] wave(input logic [15:0] bits, input int n, input int len);
    logic [63:0] w;
    w = '1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < len; j++)
        w[i*len+j] = bits[i];
    return w;
  endfunction

  task automatic send(input int k, input logic [7:0] b);
    data[k]  = b;
    valid[k] = 1'b1;
    @(negedge clk);
    valid[k] = 1'b0;
  endtask

  task automatic chk_frame(input int k, input string tag, input logic [15:0] bits,
                           input int n, input int len);
    logic [63:0] w;
    int t, dpos, dcnt;
    logic rdy_after;
    w = '1; t = 0; dpos = -1; dcnt = 0; rdy_after = 1'b0;
    while (tx_v[k] !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_start_seen"}, (t < 200), 1);
    for (int i = 0; i < n*len + 4; i++) begin
      if (i < n*len) w[i] = tx_v[k];
      if (dn_v[k]) begin
        if (dcnt == 0) dpos = i;
        dcnt++;
      end
      if (i == n*len) rdy_after = rdy_v[k];
      @(negedge clk);
    end
    chk({tag, "_wave"}, w, wave(bits, n, len));
    chk({tag, "_done_cnt"}, dcnt, 1);
    chk({tag, "_done_pos"}, dpos, n*len - 1);
    chk({tag, "_rdy_after"}, rdy_after, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int hs0, dn_before, t;
    logic seen_low;
    rst_n = 1'b0;
    baud  = 16'd3;
    valid = 3'b000;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_tx",   tx_v,  3'b111);
    chk("rst_rdy",  rdy_v, 3'b111);
    chk("rst_busy", bsy_v, 3'b000);
    chk("rst_done", dn_v,  3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tx",   tx_v,  3'b111);
    chk("idle_rdy",  rdy_v, 3'b111);
    chk("idle_busy", bsy_v, 3'b000);

    // 8N1, 4 clocks per bit
    send(0, 8'hA5);
    chk("a5_busy", bsy0, 1);
    chk_frame(0, "a5", {1'b1, 8'hA5, 1'b0}, 10, 4);

    // even parity of 0x07 is 1; two stop bits
    send(1, 8'h07);
    chk_frame(1, "e2", {2'b11, 1'b1, 8'h07, 1'b0}, 12, 4);

    // odd parity of 0x07 is 0
    send(2, 8'h07);
    chk_frame(2, "o1", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 4);

    // back-to-back with Tx_Valid held; data changed while busy
    hs0 = hs_data.size();
    data[0]  = 8'h55;
    valid[0] = 1'b1;
    @(negedge clk);
    data[0] = 8'hAA;
    chk_frame(0, "b2b1", {1'b1, 8'h55, 1'b0}, 10, 4);
    chk("b2b_hs_mid", hs_data.size() - hs0, 2);
    valid[0] = 1'b0;
    chk_frame(0, "b2b2", {1'b1, 8'hAA, 1'b0}, 10, 4);
    repeat (10) @(negedge clk);
    chk("b2b_hs_end", hs_data.size() - hs0, 2);
    chk("b2b_byte0", hs_data[hs0], 8'h55);
    chk("b2b_byte1", hs_data[hs0+1], 8'hAA);

    // Tx_Valid pulsed while busy must not start another frame
    send(1, 8'h07);
    repeat (10) @(negedge clk);
    data[1]  = 8'hFF;
    valid[1] = 1'b1;
    @(negedge clk);
    valid[1] = 1'b0;
    t = 0;
    while (bsy1 !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ign_idle_reached", (t < 200), 1);
    seen_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx1 !== 1'b1 || bsy1 !== 1'b0) seen_low = 1'b1;
      @(negedge clk);
    end
    chk("ign_no_frame", seen_low, 0);

    // reset during data bit 0 of 0x3C (line low there)
    send(0, 8'h3C);
    t = 0;
    while (tx0 !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk("mid_pre_tx",   tx0,  0);
    chk("mid_pre_busy", bsy0, 1);
    dn_before = dn0_total;
    rst_n = 1'b0;
    #1;
    chk("mid_async_tx",   tx0,  1);
    chk("mid_async_rdy",  rdy0, 1);
    chk("mid_async_done", dn0,  0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_done", dn0_total - dn_before, 0);
    chk("mid_idle_tx", tx0, 1);
    send(0, 8'hC3);
    chk_frame(0, "post_rst", {1'b1, 8'hC3, 1'b0}, 10, 4);

    // Tick held high: one bit per clock
    baud = 16'd0;
    @(negedge clk);
    send(0, 8'hFF);
    chk_frame(0, "fast", {1'b1, 8'hFF, 1'b0}, 10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
